// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the core preempt unit: FSM state encoding, the
// default stdio address and the TOY memory opcode constants.
// Ports: none (package).
// -----------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEM_REQ  = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_IO_IN    = 3'd3,
    ST_IO_OUT   = 3'd4,
    ST_WB       = 3'd5,
    ST_HALTED   = 3'd6
  } preempt_state_e;

  // Address that is redirected to stdin (load) / stdout (store).
  localparam logic [7:0] IO_ADDR_DEFAULT = 8'hFF;

  // TOY opcodes for the memory instructions handled by the unit.
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_STI = 4'hB;

  // True when the opcode is one of the memory instructions above.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST) || (op == OP_LDI) || (op == OP_STI);
  endfunction

  // Write-back value: R0 is hard-wired to zero, so a write to it only
  // clears the dirty bit and carries zero data.
  function automatic logic [15:0] wb_value(input logic [3:0] rd, input logic [15:0] data);
    return (rd == 4'd0) ? 16'h0000 : data;
  endfunction

endpackage

// File: rtl/core_preempt_unit.sv
// -----------------------------------------------------------------------------
// core_preempt_unit
// Slave end of the decoder preempt channel. Executes TOY load/store (direct and
// indirect, stdio mapped at IO_ADDR), PC redirects and halt on behalf of the
// decoder. All outputs are registered except busy_o, which is decoded from the
// state register alone.
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   lsu_en_i/lsu_wen_i/lsu_kind_i      memory op request, store flag, direct flag
//   jump_en_i/jump_kind_i              PC redirect request, immediate-target flag
//   halt_i, run_i                      enter / leave HALTED
//   instr_i, rd_val_i, rt_val_i        owning instruction and operand values
//   busy_o                             unit occupied (cascade-head stall)
//   mem_req_o/we/addr/wdata, mem_gnt_i  memory request channel
//   mem_rvalid_i, mem_rdata_i          memory load response
//   in_valid_i/in_ready_o/in_data_i    stdin handshake
//   out_valid_o/out_ready_i/out_data_o stdout handshake
//   wb_en_o/wb_addr_o/wb_data_o        ARF write-back port
//   pc_load_o/pc_target_o              PC redirect strobe and target
//   halted_o                           core halted
// -----------------------------------------------------------------------------
module core_preempt_unit
  import core_pkg::*;
#(
  parameter logic [7:0] IO_ADDR = IO_ADDR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_en_i,
  input  logic        lsu_wen_i,
  input  logic        lsu_kind_i,
  input  logic        jump_en_i,
  input  logic        jump_kind_i,
  input  logic        halt_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] rd_val_i,
  input  logic [15:0] rt_val_i,
  output logic        busy_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [7:0]  mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [15:0] mem_rdata_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] out_data_o,
  output logic        wb_en_o,
  output logic [3:0]  wb_addr_o,
  output logic [15:0] wb_data_o,
  output logic        pc_load_o,
  output logic [7:0]  pc_target_o,
  output logic        halted_o,
  input  logic        run_i
);

  preempt_state_e r_state;
  logic [3:0]  r_rd;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [7:0]  r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [15:0] r_out_data;
  logic        r_wb_en;
  logic [3:0]  r_wb_addr;
  logic [15:0] r_wb_data;
  logic        r_pc_load;
  logic [7:0]  r_pc_target;
  logic        r_halted;

  logic [7:0]  w_addr;
  logic [7:0]  w_jump_tgt;
  logic        w_unused;

  assign w_addr     = lsu_kind_i  ? instr_i[7:0] : rt_val_i[7:0];
  assign w_jump_tgt = jump_kind_i ? instr_i[7:0] : rd_val_i[7:0];
  // Opcode and upper address bits are decoded upstream; nothing here needs them.
  assign w_unused   = ^{instr_i[15:12], rt_val_i[15:8]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_rd        <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_wb_en     <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_pc_load   <= 1'b0;
      r_pc_target <= '0;
      r_halted    <= 1'b0;
    end else begin
      // Single-cycle strobes and their payloads fall back to zero by default.
      r_wb_en     <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_pc_load   <= 1'b0;
      r_pc_target <= '0;

      case (r_state)
        ST_IDLE: begin
          // Priority halt > jump > lsu guards against a protocol violation.
          if (halt_i) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else if (jump_en_i) begin
            r_pc_load   <= 1'b1;
            r_pc_target <= w_jump_tgt;
          end else if (lsu_en_i) begin
            r_rd <= instr_i[11:8];
            if (w_addr == IO_ADDR) begin
              if (lsu_wen_i) begin
                r_state     <= ST_IO_OUT;
                r_out_valid <= 1'b1;
                r_out_data  <= rd_val_i;
              end else begin
                r_state    <= ST_IO_IN;
                r_in_ready <= 1'b1;
              end
            end else begin
              r_state     <= ST_MEM_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= lsu_wen_i;
              r_mem_addr  <= w_addr;
              r_mem_wdata <= rd_val_i;
            end
          end
        end

        ST_MEM_REQ: begin
          if (mem_gnt_i) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            if (r_mem_we) begin
              r_state <= ST_IDLE;
            end else if (mem_rvalid_i) begin
              // Zero-latency memory: data arrives with the grant.
              r_state   <= ST_WB;
              r_wb_en   <= 1'b1;
              r_wb_addr <= r_rd;
              r_wb_data <= wb_value(r_rd, mem_rdata_i);
            end else begin
              r_state <= ST_MEM_WAIT;
            end
          end
        end

        ST_MEM_WAIT: begin
          if (mem_rvalid_i) begin
            r_state   <= ST_WB;
            r_wb_en   <= 1'b1;
            r_wb_addr <= r_rd;
            r_wb_data <= wb_value(r_rd, mem_rdata_i);
          end
        end

        ST_IO_IN: begin
          if (in_valid_i) begin
            r_in_ready <= 1'b0;
            r_state    <= ST_WB;
            r_wb_en    <= 1'b1;
            r_wb_addr  <= r_rd;
            r_wb_data  <= wb_value(r_rd, in_data_i);
          end
        end

        ST_IO_OUT: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_state     <= ST_IDLE;
          end
        end

        // The write-back strobe was raised on entry; it lasts exactly this cycle.
        ST_WB: r_state <= ST_IDLE;

        ST_HALTED: begin
          if (run_i) begin
            r_halted <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o      = (r_state != ST_IDLE);
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign wb_en_o     = r_wb_en;
  assign wb_addr_o   = r_wb_addr;
  assign wb_data_o   = r_wb_data;
  assign pc_load_o   = r_pc_load;
  assign pc_target_o = r_pc_target;
  assign halted_o    = r_halted;

  // Requests are one-hot by protocol.
  a_req_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({halt_i, jump_en_i, lsu_en_i}))
    else $error("preempt requests not mutually exclusive");

  // A request while busy is dropped; flag it without stopping the run.
  a_req_while_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    busy_o |-> !(halt_i || jump_en_i || lsu_en_i))
    else $warning("preempt request dropped while unit busy");

endmodule

// File: tb/tb_core_preempt_unit.sv
module tb_core_preempt_unit;
  import core_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        lsu_en_i = 1'b0, lsu_wen_i = 1'b0, lsu_kind_i = 1'b0;
  logic        jump_en_i = 1'b0, jump_kind_i = 1'b0, halt_i = 1'b0, run_i = 1'b0;
  logic [15:0] instr_i = '0, rd_val_i = '0, rt_val_i = '0;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [15:0] mem_rdata_i = '0;
  logic        in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [15:0] in_data_i = '0;

  logic        busy_o, mem_req_o, mem_we_o, in_ready_o, out_valid_o;
  logic        wb_en_o, pc_load_o, halted_o;
  logic [7:0]  mem_addr_o, pc_target_o;
  logic [15:0] mem_wdata_o, out_data_o, wb_data_o;
  logic [3:0]  wb_addr_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural memory: the bench plays the memory, stores update it.
  logic [15:0] mem_model [256];

  always #5 clk_i = ~clk_i;

  core_preempt_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lsu_en_i(lsu_en_i), .lsu_wen_i(lsu_wen_i), .lsu_kind_i(lsu_kind_i),
    .jump_en_i(jump_en_i), .jump_kind_i(jump_kind_i), .halt_i(halt_i),
    .instr_i(instr_i), .rd_val_i(rd_val_i), .rt_val_i(rt_val_i),
    .busy_o(busy_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .pc_load_o(pc_load_o), .pc_target_o(pc_target_o), .halted_o(halted_o),
    .run_i(run_i)
  );

  task automatic check(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {busy_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, in_ready_o,
                out_valid_o, out_data_o, wb_en_o, wb_addr_o, wb_data_o, pc_load_o,
                pc_target_o, halted_o}, 80'h0);
  endtask

  // Issue an lsu request; the address comes from instr (direct) or rt (indirect).
  task automatic issue_lsu(input logic wen, input logic kind, input logic [3:0] rd,
                           input logic [7:0] addr, input logic [15:0] wd);
    logic [3:0] op;
    op = wen ? (kind ? OP_ST : OP_STI) : (kind ? OP_LD : OP_LDI);
    lsu_en_i   = 1'b1;
    lsu_wen_i  = wen;
    lsu_kind_i = kind;
    instr_i    = {op, rd, kind ? addr : 8'($urandom)};
    rt_val_i   = kind ? 16'($urandom) : {8'($urandom), addr};
    rd_val_i   = wd;
    tick();
    // Scramble operands: the unit must have latched what it needs.
    lsu_en_i = 1'b0;
    instr_i  = 16'($urandom);
    rt_val_i = 16'($urandom);
    rd_val_i = 16'($urandom);
  endtask

  task automatic mem_op(input logic wen, input logic kind, input logic [3:0] rd,
                        input logic [7:0] addr, input logic [15:0] wd,
                        input int gnt_dly, input int rv_dly);
    logic [15:0] exp;
    issue_lsu(wen, kind, rd, addr, wd);
    check("mem_req", {busy_o, mem_req_o, mem_we_o, mem_addr_o}, {1'b1, 1'b1, wen, addr});
    if (wen) check("mem_wdata", mem_wdata_o, wd);
    for (int i = 0; i < gnt_dly; i++) begin
      tick();
      check("req_hold", {busy_o, mem_req_o, mem_we_o, mem_addr_o}, {1'b1, 1'b1, wen, addr});
      if (wen) check("wdata_hold", mem_wdata_o, wd);
    end
    mem_gnt_i = 1'b1;
    if (!wen && rv_dly == 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_model[addr];
    end
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 16'($urandom);
    check("req_drop", mem_req_o, 0);
    if (wen) begin
      mem_model[addr] = wd;
      check("st_idle", {busy_o, wb_en_o}, 0);
    end else begin
      if (rv_dly > 0) begin
        check("wait_busy", {busy_o, wb_en_o}, {1'b1, 1'b0});
        for (int i = 1; i < rv_dly; i++) begin
          tick();
          check("wb_early", {busy_o, wb_en_o}, {1'b1, 1'b0});
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_model[addr];
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 16'($urandom);
      end
      exp = (rd == 4'd0) ? 16'h0 : mem_model[addr];
      check("ld_wb", {wb_en_o, wb_addr_o, wb_data_o}, {1'b1, rd, exp});
      tick();
      check("ld_done", {busy_o, wb_en_o}, 0);
    end
    $display("[TB] mem %s kind=%0d rd=%0d addr=%h data=%h gnt_dly=%0d rv_dly=%0d",
             wen ? "store" : "load", kind, rd, addr, wen ? wd : mem_model[addr], gnt_dly, rv_dly);
  endtask

  task automatic io_load(input logic kind, input logic [3:0] rd, input int dly,
                         input logic [15:0] data);
    issue_lsu(1'b0, kind, rd, 8'hFF, 16'($urandom));
    check("in_ready", {busy_o, in_ready_o, mem_req_o}, {1'b1, 1'b1, 1'b0});
    for (int i = 0; i < dly; i++) begin
      tick();
      check("in_wait", {busy_o, in_ready_o, wb_en_o}, {1'b1, 1'b1, 1'b0});
    end
    in_valid_i = 1'b1;
    in_data_i  = data;
    tick();
    in_valid_i = 1'b0;
    in_data_i  = 16'($urandom);
    check("in_wb", {in_ready_o, wb_en_o, wb_addr_o, wb_data_o},
          {1'b0, 1'b1, rd, (rd == 4'd0) ? 16'h0 : data});
    tick();
    check("in_done", {busy_o, wb_en_o}, 0);
    $display("[TB] stdin  kind=%0d rd=%0d data=%h dly=%0d", kind, rd, data, dly);
  endtask

  task automatic io_store(input logic kind, input logic [15:0] wd, input int dly);
    issue_lsu(1'b1, kind, 4'($urandom), 8'hFF, wd);
    check("out_valid", {busy_o, out_valid_o, out_data_o, mem_req_o}, {1'b1, 1'b1, wd, 1'b0});
    for (int i = 0; i < dly; i++) begin
      tick();
      check("out_hold", {busy_o, out_valid_o, out_data_o}, {1'b1, 1'b1, wd});
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("out_done", {busy_o, out_valid_o, wb_en_o}, 0);
    $display("[TB] stdout kind=%0d data=%h dly=%0d", kind, wd, dly);
  endtask

  task automatic do_jump(input logic kind, input logic [7:0] tgt);
    jump_en_i   = 1'b1;
    jump_kind_i = kind;
    instr_i     = {4'hC, 4'($urandom), kind ? tgt : 8'($urandom)};
    rd_val_i    = kind ? 16'($urandom) : {8'($urandom), tgt};
    tick();
    jump_en_i = 1'b0;
    instr_i   = 16'($urandom);
    rd_val_i  = 16'($urandom);
    check("pc_load", {busy_o, pc_load_o, pc_target_o}, {1'b0, 1'b1, tgt});
    tick();
    check("pc_once", {busy_o, pc_load_o}, 0);
    $display("[TB] jump   kind=%0d target=%h", kind, tgt);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 16'(i * 257) ^ 16'h5A5A;
    mem_model[8'h20] = 16'h1234;

    tick();
    tick();
    check_all_zero("reset_state");
    rst_ni = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Directed cases
    mem_op(1'b0, 1'b1, 4'd3, 8'h20, 16'h0, 0, 1);
    mem_op(1'b1, 1'b0, 4'd5, 8'h42, 16'hBEEF, 4, 0);
    mem_op(1'b0, 1'b1, 4'd7, 8'h42, 16'h0, 1, 2);
    mem_op(1'b0, 1'b0, 4'd0, 8'h20, 16'h0, 0, 1);
    mem_op(1'b0, 1'b1, 4'd9, 8'h33, 16'h0, 2, 0);
    io_load(1'b1, 4'd4, 5, 16'h00AA);
    io_store(1'b0, 16'hC0DE, 6);
    do_jump(1'b0, 8'h10);
    do_jump(1'b1, 8'hE7);

    // Halt: requests ignored until run
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    check("halted", {halted_o, busy_o, mem_req_o}, {1'b1, 1'b1, 1'b0});
    lsu_en_i   = 1'b1;
    lsu_wen_i  = 1'b0;
    lsu_kind_i = 1'b1;
    instr_i    = {OP_LD, 4'h2, 8'h30};
    tick();
    lsu_en_i = 1'b0;
    check("halt_ignores_lsu", {halted_o, busy_o, mem_req_o, in_ready_o}, {1'b1, 1'b1, 1'b0, 1'b0});
    tick();
    tick();
    check("halt_holds", {halted_o, busy_o}, {1'b1, 1'b1});
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    check_all_zero("run_idle");
    tick();
    check_all_zero("run_stays_idle");
    $display("[TB] halt/run");

    // Reset during MEM_WAIT
    issue_lsu(1'b0, 1'b1, 4'd6, 8'h55, 16'h0);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    check("wait_before_rst", {busy_o, mem_req_o}, {1'b1, 1'b0});
    rst_ni = 1'b0;
    #1;
    check_all_zero("async_reset");
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 16'hDEAD;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    check_all_zero("late_rvalid");
    tick();
    check_all_zero("late_rvalid2");
    $display("[TB] reset during MEM_WAIT");

    // Randomised traffic
    for (int n = 0; n < 80; n++) begin
      int op;
      op = $urandom_range(0, 5);
      case (op)
        0: mem_op(1'b0, 1'($urandom), 4'($urandom), 8'($urandom_range(16, 31)), 16'h0,
                  $urandom_range(0, 3), $urandom_range(0, 3));
        1: mem_op(1'b1, 1'($urandom), 4'($urandom), 8'($urandom_range(16, 31)), 16'($urandom),
                  $urandom_range(0, 3), 0);
        2: io_load(1'($urandom), 4'($urandom), $urandom_range(0, 4), 16'($urandom));
        3: io_store(1'($urandom), 16'($urandom), $urandom_range(0, 4));
        4: do_jump(1'($urandom), 8'($urandom));
        default: begin
          tick();
          check_all_zero("idle_gap");
          $display("[TB] idle");
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
